// File: rtl/axi_ipif_pkg.sv
// Shared types and constants for the AXI4-Lite to IPIF bridge.
package axi_ipif_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StWrReq,
        StRdReq,
        StWrResp,
        StRdResp
    } ipif_state_e;

    // Inclusive range test; operands are zero-extended so any address width up to 64 works.
    function automatic logic addr_in_range(input logic [63:0] addr,
                                           input logic [63:0] base,
                                           input logic [63:0] high);
        return (addr >= base) && (addr <= high);
    endfunction

    // Response code for an access the slave acknowledged.
    function automatic logic [1:0] ack_resp(input logic err);
        return err ? RESP_SLVERR : RESP_OKAY;
    endfunction

endpackage

// File: rtl/ipif_ack_timer.sv
// Counts IPIF request cycles and flags the last cycle before a no-ack timeout.
module ipif_ack_timer
    import axi_ipif_pkg::*;
#(
    parameter int unsigned C_TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CntW = $clog2(C_TIMEOUT + 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // expired_o is high during the C_TIMEOUT-th enabled cycle, so the owner leaves on that edge.
    assign expired_o = (cnt_q == CntW'(C_TIMEOUT - 1));

    // Next count: restart on load, advance while enabled, saturate once expired.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (en_i && !expired_o) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/axi4lite_ipif_bridge.sv
// AXI4-Lite slave that converts single-beat reads/writes into IPIF Bus2IP_* cycles,
// with address decode and a no-ack timeout.
module axi4lite_ipif_bridge
    import axi_ipif_pkg::*;
#(
    parameter int unsigned                   C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned                   C_S_AXI_ADDR_WIDTH = 32,
    parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_BASEADDR = C_S_AXI_ADDR_WIDTH'(32'hFFFF_FFFF),
    parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_HIGHADDR = C_S_AXI_ADDR_WIDTH'(32'h0000_0000),
    parameter int unsigned                   C_TIMEOUT  = 16
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic                              Bus2IP_Clk,
    output logic                              Bus2IP_Resetn,
    output logic [C_S_AXI_ADDR_WIDTH-1:0]     Bus2IP_Addr,
    output logic                              Bus2IP_CS,
    output logic                              Bus2IP_RNW,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     Bus2IP_Data,
    output logic [C_S_AXI_DATA_WIDTH/8-1:0]   Bus2IP_BE,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     IP2Bus_Data,
    input  logic                              IP2Bus_RdAck,
    input  logic                              IP2Bus_WrAck,
    input  logic                              IP2Bus_Error
);

    localparam int unsigned AW = C_S_AXI_ADDR_WIDTH;
    localparam int unsigned DW = C_S_AXI_DATA_WIDTH;
    localparam int unsigned SW = C_S_AXI_DATA_WIDTH / 8;

    ipif_state_e   state_q, state_d;
    logic          ready_en_q;
    logic          aw_held_q, aw_held_d;
    logic          w_held_q, w_held_d;
    logic [AW-1:0] awaddr_q, awaddr_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;
    logic [SW-1:0] be_q, be_d;
    logic          cs_q, cs_d;
    logic          rnw_q, rnw_d;
    logic [1:0]    bresp_q, bresp_d;
    logic [1:0]    rresp_q, rresp_d;
    logic [DW-1:0] rdata_q, rdata_d;

    logic          idle;
    logic          in_req;
    logic          aw_fire, w_fire, ar_fire;
    logic          wr_go;
    logic [AW-1:0] wr_addr;
    logic          timer_load;
    logic          timer_expired;

    // ready_en_q keeps every READY low while reset is asserted and for the first cycle after.
    assign idle    = (state_q == StIdle) && ready_en_q;
    assign in_req  = (state_q == StWrReq) || (state_q == StRdReq);

    // A write is complete when AW and W are each either held or arriving this cycle.
    assign wr_go   = idle && (aw_held_q || S_AXI_AWVALID) && (w_held_q || S_AXI_WVALID);
    assign wr_addr = aw_held_q ? awaddr_q : S_AXI_AWADDR;

    assign S_AXI_AWREADY = idle && !aw_held_q;
    assign S_AXI_WREADY  = idle && !w_held_q;
    // A complete write always wins, so AR is refused in the cycle one becomes complete.
    assign S_AXI_ARREADY = idle && !wr_go;

    assign aw_fire = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_fire  = S_AXI_WVALID && S_AXI_WREADY;
    assign ar_fire = S_AXI_ARVALID && S_AXI_ARREADY;

    assign S_AXI_BVALID = (state_q == StWrResp);
    assign S_AXI_RVALID = (state_q == StRdResp);
    assign S_AXI_BRESP  = bresp_q;
    assign S_AXI_RRESP  = rresp_q;
    assign S_AXI_RDATA  = rdata_q;

    assign Bus2IP_Clk    = S_AXI_ACLK;
    assign Bus2IP_Resetn = S_AXI_ARESETN;
    assign Bus2IP_Addr   = addr_q;
    assign Bus2IP_CS     = cs_q;
    assign Bus2IP_RNW    = rnw_q;
    assign Bus2IP_Data   = data_q;
    assign Bus2IP_BE     = be_q;

    ipif_ack_timer #(
        .C_TIMEOUT (C_TIMEOUT)
    ) u_ack_timer (
        .clk_i     (S_AXI_ACLK),
        .rst_ni    (S_AXI_ARESETN),
        .load_i    (timer_load),
        .en_i      (in_req),
        .expired_o (timer_expired)
    );

    // Next-state: channel capture, arbitration, decode, ack/timeout handling.
    always_comb begin
        state_d    = state_q;
        aw_held_d  = aw_held_q;
        w_held_d   = w_held_q;
        awaddr_d   = awaddr_q;
        addr_d     = addr_q;
        data_d     = data_q;
        be_d       = be_q;
        cs_d       = cs_q;
        rnw_d      = rnw_q;
        bresp_d    = bresp_q;
        rresp_d    = rresp_q;
        rdata_d    = rdata_q;
        timer_load = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (aw_fire) begin
                    aw_held_d = 1'b1;
                    awaddr_d  = S_AXI_AWADDR;
                end
                if (w_fire) begin
                    w_held_d = 1'b1;
                    data_d   = S_AXI_WDATA;
                    be_d     = S_AXI_WSTRB;
                end
                if (wr_go) begin
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    addr_d    = wr_addr;
                    rnw_d     = 1'b0;
                    if (addr_in_range(64'(wr_addr), 64'(C_BASEADDR), 64'(C_HIGHADDR))) begin
                        state_d    = StWrReq;
                        cs_d       = 1'b1;
                        timer_load = 1'b1;
                    end else begin
                        state_d = StWrResp;
                        bresp_d = RESP_DECERR;
                    end
                end else if (ar_fire) begin
                    addr_d = S_AXI_ARADDR;
                    rnw_d  = 1'b1;
                    if (addr_in_range(64'(S_AXI_ARADDR), 64'(C_BASEADDR), 64'(C_HIGHADDR))) begin
                        state_d    = StRdReq;
                        cs_d       = 1'b1;
                        timer_load = 1'b1;
                    end else begin
                        state_d = StRdResp;
                        rresp_d = RESP_DECERR;
                        rdata_d = '0;
                    end
                end
            end
            StWrReq: begin
                if (IP2Bus_WrAck) begin
                    state_d = StWrResp;
                    cs_d    = 1'b0;
                    bresp_d = ack_resp(IP2Bus_Error);
                end else if (timer_expired) begin
                    state_d = StWrResp;
                    cs_d    = 1'b0;
                    bresp_d = RESP_SLVERR;
                end
            end
            StRdReq: begin
                if (IP2Bus_RdAck) begin
                    state_d = StRdResp;
                    cs_d    = 1'b0;
                    rresp_d = ack_resp(IP2Bus_Error);
                    rdata_d = IP2Bus_Data;
                end else if (timer_expired) begin
                    state_d = StRdResp;
                    cs_d    = 1'b0;
                    rresp_d = RESP_SLVERR;
                    rdata_d = '0;
                end
            end
            StWrResp: begin
                if (S_AXI_BREADY) begin
                    state_d = StIdle;
                end
            end
            StRdResp: begin
                if (S_AXI_RREADY) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                cs_d    = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset drops any in-flight access.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_q    <= StIdle;
            ready_en_q <= 1'b0;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            awaddr_q   <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            be_q       <= '0;
            cs_q       <= 1'b0;
            rnw_q      <= 1'b1;
            bresp_q    <= RESP_OKAY;
            rresp_q    <= RESP_OKAY;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            ready_en_q <= 1'b1;
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            awaddr_q   <= awaddr_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            be_q       <= be_d;
            cs_q       <= cs_d;
            rnw_q      <= rnw_d;
            bresp_q    <= bresp_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
        end
    end

endmodule

// File: tb/tb_axi4lite_ipif_bridge.sv
// Self-checking bench: randomized AXI traffic against a responding IPIF slave and a
// transaction-level expectation model.
module tb_axi4lite_ipif_bridge;

    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam logic [31:0] HIGH = 32'h4000_0FFF;
    localparam int          TMO  = 16;

    logic        clk;
    logic        rst_n;
    logic [31:0] awaddr;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid, wready;
    logic [1:0]  bresp;
    logic        bvalid, bready;
    logic [31:0] araddr;
    logic        arvalid, arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid, rready;
    logic        ip_clk, ip_resetn;
    logic [31:0] ip_addr;
    logic        ip_cs, ip_rnw;
    logic [31:0] ip_wdata;
    logic [3:0]  ip_be;
    logic [31:0] ip_rdata;
    logic        ip_rdack, ip_wrack, ip_error;

    axi4lite_ipif_bridge #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (32),
        .C_BASEADDR         (BASE),
        .C_HIGHADDR         (HIGH),
        .C_TIMEOUT          (TMO)
    ) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .Bus2IP_Clk    (ip_clk),
        .Bus2IP_Resetn (ip_resetn),
        .Bus2IP_Addr   (ip_addr),
        .Bus2IP_CS     (ip_cs),
        .Bus2IP_RNW    (ip_rnw),
        .Bus2IP_Data   (ip_wdata),
        .Bus2IP_BE     (ip_be),
        .IP2Bus_Data   (ip_rdata),
        .IP2Bus_RdAck  (ip_rdack),
        .IP2Bus_WrAck  (ip_wrack),
        .IP2Bus_Error  (ip_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic bit in_range(input logic [31:0] a);
        return (a >= BASE) && (a <= HIGH);
    endfunction

    function automatic int widx(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return int'(off[11:2]);
    endfunction

    // Slave word storage and the bench's independent expectation of it.
    logic [31:0] slv_mem [1024];
    logic [31:0] exp_mem [1024];

    // Slave behaviour knobs.
    int slv_delay = 0;
    bit slv_err   = 0;
    bit slv_noack = 0;
    bit slv_dbl   = 0;

    // Slave observations.
    int          cs_rises    = 0;
    int          cs_len      = 0;
    int          last_cs_len = 0;
    logic [31:0] cap_addr, cap_data;
    logic [3:0]  cap_be;
    logic        cap_rnw;

    // IPIF slave: acks slv_delay cycles after CS rises, optionally with a stray second pulse.
    initial begin
        int  wait_cnt;
        bit  acked, dbl_pend, prev_cs, last_rnw;
        wait_cnt = 0; acked = 0; dbl_pend = 0; prev_cs = 0; last_rnw = 0;
        ip_rdack = 0; ip_wrack = 0; ip_error = 0; ip_rdata = '0;
        forever begin
            @(negedge clk);
            ip_rdack = 0; ip_wrack = 0; ip_error = 0; ip_rdata = $urandom;
            if (dbl_pend) begin
                if (last_rnw) ip_rdack = 1; else ip_wrack = 1;
                dbl_pend = 0;
            end
            if (ip_cs === 1'b1) begin
                if (!prev_cs) cs_rises++;
                cs_len++;
                if (!acked && !slv_noack) begin
                    if (wait_cnt == slv_delay) begin
                        acked    = 1;
                        cap_addr = ip_addr; cap_data = ip_wdata; cap_be = ip_be; cap_rnw = ip_rnw;
                        last_rnw = ip_rnw;
                        ip_error = slv_err;
                        dbl_pend = slv_dbl;
                        if (ip_rnw) begin
                            ip_rdack = 1;
                            ip_rdata = slv_mem[widx(ip_addr)];
                        end else begin
                            ip_wrack = 1;
                            if (!slv_err)
                                slv_mem[widx(ip_addr)] = merge(slv_mem[widx(ip_addr)], ip_wdata, ip_be);
                        end
                    end else begin
                        wait_cnt++;
                    end
                end
            end else begin
                if (prev_cs) last_cs_len = cs_len;
                cs_len = 0; wait_cnt = 0; acked = 0;
            end
            prev_cs = (ip_cs === 1'b1);
        end
    end

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_awready"}, awready, 0);
        check_eq({tag, "_wready"}, wready, 0);
        check_eq({tag, "_arready"}, arready, 0);
        check_eq({tag, "_bvalid"}, bvalid, 0);
        check_eq({tag, "_rvalid"}, rvalid, 0);
        check_eq({tag, "_cs"}, ip_cs, 0);
        check_eq({tag, "_rnw"}, ip_rnw, 1);
        check_eq({tag, "_addr"}, ip_addr, 0);
        check_eq({tag, "_data"}, ip_wdata, 0);
        check_eq({tag, "_be"}, ip_be, 0);
        check_eq({tag, "_resp"}, {bresp, rresp}, 0);
        check_eq({tag, "_rdata"}, rdata, 0);
        check_eq({tag, "_resetn"}, ip_resetn, 0);
    endtask

    // One write and/or one read, with expectations derived from the decode/ack/timeout rules.
    task automatic run_txn(input string tag, input bit do_wr, input logic [31:0] waddr,
                           input logic [31:0] wd, input logic [3:0] ws, input int aw_dly,
                           input int w_dly, input bit do_rd, input logic [31:0] raddr,
                           input int ar_dly, input int b_hold, input int r_hold);
        bit          wr_in, rd_in, aw_p, w_p, ar_p, b_p, r_p, aw_f, w_f, ar_f, b_f, r_f;
        logic [1:0]  exp_bresp, exp_rresp;
        logic [31:0] exp_rdata;
        int          lat, aw_it, w_it, ar_it, bv_it, rv_it, b_done_it, cs0, n_in;

        wr_in = do_wr && in_range(waddr);
        rd_in = do_rd && in_range(raddr);
        lat   = slv_noack ? TMO + 1 : slv_delay + 2;
        exp_bresp = !in_range(waddr) ? 2'b11 : (slv_noack || slv_err) ? 2'b10 : 2'b00;
        exp_rresp = !in_range(raddr) ? 2'b11 : (slv_noack || slv_err) ? 2'b10 : 2'b00;
        if (wr_in && !slv_noack && !slv_err) exp_mem[widx(waddr)] = merge(exp_mem[widx(waddr)], wd, ws);
        exp_rdata = (!rd_in || slv_noack) ? 32'h0 : exp_mem[widx(raddr)];

        cap_addr = '0; cap_data = '0; cap_be = '0; cap_rnw = 1'bx;
        cs0 = cs_rises;
        aw_p = do_wr; w_p = do_wr; ar_p = do_rd; b_p = do_wr; r_p = do_rd;
        aw_it = -1; w_it = -1; ar_it = -1; bv_it = -1; rv_it = -1; b_done_it = -1;

        for (int it = 0; it < 300 && (aw_p || w_p || ar_p || b_p || r_p); it++) begin
            @(negedge clk);
            awaddr = waddr; wdata = wd; wstrb = ws; araddr = raddr;
            awvalid = aw_p && (it >= aw_dly);
            wvalid  = w_p && (it >= w_dly);
            arvalid = ar_p && (it >= ar_dly);
            #1;
            if (bvalid) begin
                if (!b_p) begin
                    check_eq({tag, "_extra_b"}, 1, 0);
                    bready = 1;
                end else begin
                    if (bv_it < 0) begin
                        bv_it = it;
                        check_eq({tag, "_b_lat"}, it - (aw_it > w_it ? aw_it : w_it),
                                 wr_in ? lat : 1);
                    end
                    check_eq({tag, "_bresp"}, bresp, exp_bresp);
                    bready = (it - bv_it) >= b_hold;
                end
            end else bready = 0;
            if (rvalid) begin
                if (!r_p) begin
                    check_eq({tag, "_extra_r"}, 1, 0);
                    rready = 1;
                end else begin
                    if (rv_it < 0) begin
                        rv_it = it;
                        check_eq({tag, "_r_lat"}, it - ar_it, rd_in ? lat : 1);
                    end
                    check_eq({tag, "_rresp"}, rresp, exp_rresp);
                    check_eq({tag, "_rdata"}, rdata, exp_rdata);
                    rready = (it - rv_it) >= r_hold;
                end
            end else rready = 0;
            aw_f = awvalid && awready;
            w_f  = wvalid && wready;
            ar_f = arvalid && arready;
            b_f  = bvalid && bready && b_p;
            r_f  = rvalid && rready && r_p;
            if (aw_f || w_f) check_eq({tag, "_cs_before_wr"}, cs_rises - cs0, 0);
            if (ar_f && do_wr) check_eq({tag, "_rd_after_b"}, (b_done_it >= 0) && (b_done_it < it), 1);
            if (aw_f) begin aw_p = 0; aw_it = it; end
            if (w_f)  begin w_p = 0;  w_it = it;  end
            if (ar_f) begin ar_p = 0; ar_it = it; end
            if (b_f)  begin b_p = 0;  b_done_it = it; end
            if (r_f)  r_p = 0;
        end
        check_eq({tag, "_hang"}, {aw_p, w_p, ar_p, b_p, r_p}, 0);

        @(negedge clk);
        awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0;
        @(negedge clk);
        #2;
        check_eq({tag, "_idle_valid"}, {bvalid, rvalid}, 0);
        n_in = int'(wr_in) + int'(rd_in);
        check_eq({tag, "_cs_count"}, cs_rises - cs0, n_in);
        if (n_in == 1) check_eq({tag, "_cs_len"}, last_cs_len, slv_noack ? TMO : slv_delay + 1);
        if (wr_in && !do_rd && !slv_noack) begin
            check_eq({tag, "_ip_waddr"}, cap_addr, waddr);
            check_eq({tag, "_ip_wdata"}, cap_data, wd);
            check_eq({tag, "_ip_be"}, cap_be, ws);
            check_eq({tag, "_ip_rnw_w"}, cap_rnw, 0);
        end
        if (rd_in && !slv_noack) begin
            check_eq({tag, "_ip_raddr"}, cap_addr, raddr);
            check_eq({tag, "_ip_rnw_r"}, cap_rnw, 1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] v, a, ra, d;
        int          op, sel;

        rst_n = 0;
        awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
        araddr = '0; arvalid = 0; rready = 0;
        for (int i = 0; i < 1024; i++) begin
            v = $urandom;
            slv_mem[i] = v;
            exp_mem[i] = v;
        end
        slv_mem[2] = 32'h1234_5678;
        exp_mem[2] = 32'h1234_5678;

        repeat (3) @(negedge clk);
        #1 check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1;
        repeat (2) @(negedge clk);

        slv_delay = 1;
        run_txn("wr_base4", 1, BASE + 32'h4, 32'hA5A5_0001, 4'hF, 0, 0, 0, '0, 0, 0, 0);
        slv_delay = 0;
        run_txn("wr_wlead", 1, BASE + 32'hC, 32'hDEAD_BEEF, 4'h5, 3, 0, 0, '0, 0, 1, 0);
        run_txn("rd_back_c", 0, '0, '0, '0, 0, 0, 1, BASE + 32'hC, 0, 0, 0);
        slv_delay = 2;
        run_txn("rd_base8", 0, '0, '0, '0, 0, 0, 1, BASE + 32'h8, 0, 0, 5);
        run_txn("rd_decerr", 0, '0, '0, '0, 0, 0, 1, HIGH + 32'h4, 0, 0, 1);
        run_txn("wr_decerr", 1, BASE - 32'h4, 32'h1111_2222, 4'hF, 0, 0, 0, '0, 0, 2, 0);
        slv_noack = 1;
        run_txn("wr_timeout", 1, BASE + 32'h20, 32'h3333_4444, 4'hF, 0, 0, 0, '0, 0, 0, 0);
        slv_noack = 0;
        slv_delay = 1;
        run_txn("wr_after_to", 1, BASE + 32'h20, 32'h5555_6666, 4'hF, 0, 0, 0, '0, 0, 0, 0);
        run_txn("wr_rd_same", 1, BASE + 32'h30, 32'h0BAD_F00D, 4'hF, 0, 0, 1, BASE + 32'h30,
                0, 1, 0);
        run_txn("rd_low_edge", 0, '0, '0, '0, 0, 0, 1, BASE, 0, 0, 0);
        run_txn("rd_high_edge", 0, '0, '0, '0, 0, 0, 1, HIGH - 32'h3, 0, 0, 0);
        run_txn("rd_above", 0, '0, '0, '0, 0, 0, 1, HIGH + 32'h1, 0, 0, 0);

        // Reset in the middle of a read that the slave never acknowledges.
        slv_noack = 1;
        @(negedge clk);
        araddr = BASE + 32'h10; arvalid = 1;
        #1 check_eq("mid_arready", arready, 1);
        @(negedge clk);
        arvalid = 0;
        repeat (2) @(negedge clk);
        #1 check_eq("mid_cs_before_rst", ip_cs, 1);
        #2 rst_n = 0;
        #1 check_reset_outputs("midrst");
        repeat (2) @(negedge clk);
        rst_n = 1;
        slv_noack = 0;
        repeat (2) @(negedge clk);
        run_txn("rd_after_rst", 0, '0, '0, '0, 0, 0, 1, BASE + 32'h8, 0, 0, 0);

        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 9);
            if (sel < 8)       a = BASE + ($urandom_range(0, 1023) << 2);
            else if (sel == 8) a = HIGH + 32'h1 + ($urandom_range(0, 15) << 2);
            else               a = BASE - 32'h4 - ($urandom_range(0, 15) << 2);
            ra = ($urandom_range(0, 1) == 1) ? a : BASE + ($urandom_range(0, 1023) << 2);
            d = $urandom;
            slv_delay = $urandom_range(0, 3);
            slv_err   = ($urandom_range(0, 7) == 0);
            slv_noack = ($urandom_range(0, 15) == 0);
            slv_dbl   = ($urandom_range(0, 1) == 1);
            op = $urandom_range(0, 2);
            if (op == 0)
                run_txn($sformatf("rnd%0d_wr", n), 1, a, d, 4'($urandom_range(0, 15)),
                        $urandom_range(0, 3), $urandom_range(0, 3), 0, '0, 0,
                        $urandom_range(0, 2), 0);
            else if (op == 1)
                run_txn($sformatf("rnd%0d_rd", n), 0, '0, '0, '0, 0, 0, 1, a,
                        $urandom_range(0, 2), 0, $urandom_range(0, 2));
            else
                run_txn($sformatf("rnd%0d_wrrd", n), 1, a, d, 4'($urandom_range(0, 15)),
                        0, 0, 1, ra, 0, $urandom_range(0, 2), $urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
